// File: rtl/fw_upload_loader.sv
// UART firmware upload loader: decodes 'R' + LE size + payload + LE CRC32, packs the
// payload into 16-bit SRAM words from address 0, answers ACK/NAK and owns the CPU reset.
module fw_upload_loader #(
  parameter int MAX_BYTES      = 524288,
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        mem_req,
  output logic [17:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ready,
  output logic        cpu_resetn,
  output logic        busy,
  output logic        upload_ok
);

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  typedef enum logic [2:0] {S_IDLE, S_SIZE, S_DATA, S_WR_WAIT, S_CRC, S_RESP} state_t;

  state_t      state, state_d;
  logic [1:0]  cnt;
  logic [31:0] shreg, remaining, crc, timer;
  logic        hi, overrun, resp_ack;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  // Size and CRC fields share one LSB-first shifter; sh_word is the value once this byte lands.
  logic [31:0] sh_word;
  logic        last4, timer_run, timeout, size_big, data_last, crc_ok;
  assign sh_word   = {rx_data, shreg[31:8]};
  assign last4     = (cnt == 2'd3);
  assign timer_run = (state == S_SIZE) || (state == S_DATA) || (state == S_CRC);
  assign timeout   = timer_run && !rx_valid && (timer == 32'(TIMEOUT_CYCLES - 1));
  assign size_big  = sh_word > 32'(MAX_BYTES);
  assign data_last = (remaining == 32'd1);
  assign crc_ok    = (sh_word == ~crc) && !overrun;

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= S_IDLE;
    else         state <= state_d;

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:    if (rx_valid && rx_data == 8'h52) state_d = S_SIZE;
      S_SIZE:    if (timeout) state_d = S_IDLE;
                 else if (rx_valid && last4)
                   state_d = size_big ? S_IDLE : ((sh_word == 32'd0) ? S_CRC : S_DATA);
      S_DATA:    if (timeout) state_d = S_IDLE;
                 else if (rx_valid && (hi || data_last)) state_d = S_WR_WAIT;
      S_WR_WAIT: if (mem_ready) state_d = (remaining == 32'd0) ? S_CRC : S_DATA;
      S_CRC:     if (timeout) state_d = S_IDLE;
                 else if (rx_valid && last4) state_d = S_RESP;
      S_RESP:    if (tx_valid && tx_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req = (state == S_WR_WAIT);
    busy    = (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt        <= '0;
      shreg      <= '0;
      remaining  <= '0;
      crc        <= '1;
      timer      <= '0;
      hi         <= 1'b0;
      overrun    <= 1'b0;
      resp_ack   <= 1'b0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_resetn <= 1'b0;
      upload_ok  <= 1'b0;
    end else begin
      timer <= (timer_run && !rx_valid) ? timer + 32'd1 : 32'd0;
      if (tx_valid && tx_ready) tx_valid <= 1'b0;
      if (timeout) begin
        tx_valid <= 1'b1;
        tx_data  <= NAK;
      end
      case (state)
        S_IDLE: if (rx_valid) begin
          if (rx_data == 8'h52) begin
            cpu_resetn <= 1'b0;
            upload_ok  <= 1'b0;
            cnt        <= '0;
            remaining  <= '0;
            mem_addr   <= '0;
            crc        <= '1;
            hi         <= 1'b0;
            overrun    <= 1'b0;
          end else if (rx_data == 8'h72) begin
            cpu_resetn <= 1'b1;
          end
        end
        S_SIZE: if (rx_valid) begin
          shreg <= sh_word;
          cnt   <= cnt + 2'd1;
          if (last4) begin
            remaining <= sh_word;
            if (size_big) begin
              tx_valid <= 1'b1;
              tx_data  <= NAK;
            end
          end
        end
        S_DATA: if (rx_valid) begin
          crc       <= crc_byte(crc, rx_data);
          remaining <= remaining - 32'd1;
          hi        <= !hi;
          if (!hi) mem_wdata <= {8'h00, rx_data};
          else     mem_wdata[15:8] <= rx_data;
        end
        S_WR_WAIT: begin
          if (rx_valid)  overrun  <= 1'b1;
          if (mem_ready) mem_addr <= mem_addr + 18'd1;
        end
        S_CRC: if (rx_valid) begin
          shreg <= sh_word;
          cnt   <= cnt + 2'd1;
          if (last4) begin
            resp_ack <= crc_ok;
            tx_valid <= 1'b1;
            tx_data  <= crc_ok ? ACK : NAK;
          end
        end
        S_RESP: if (tx_valid && tx_ready) upload_ok <= resp_ack;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fw_upload_loader.sv
// Directed bench for fw_upload_loader: SRAM responder and TX monitor log traffic,
// each scenario task compares the logs and outputs against hand-computed values.
module tb_fw_upload_loader;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b1;
  logic        mem_req;
  logic [17:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic        cpu_resetn, busy, upload_ok;
  logic        hold_ready = 1'b0;

  int pass = 0, total = 0;
  int wr_count = 0, tx_count = 0;
  logic [7:0]  tx_last = 8'h00;
  logic [17:0] wr_addr_log [64];
  logic [15:0] wr_data_log [64];
  logic [15:0] exp_w [5] = '{16'h3231, 16'h3433, 16'h3635, 16'h3837, 16'h0039};
  string msg = "123456789";

  fw_upload_loader #(.MAX_BYTES(524288), .TIMEOUT_CYCLES(200)) dut (
    .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .cpu_resetn(cpu_resetn), .busy(busy), .upload_ok(upload_ok));

  always #5 clk = ~clk;

  // SRAM model: one-cycle ready pulse per request unless held off
  always @(negedge clk) begin
    if (!resetn || hold_ready || !mem_req || mem_ready) mem_ready = 1'b0;
    else begin
      mem_ready = 1'b1;
      wr_addr_log[wr_count % 64] = mem_addr;
      wr_data_log[wr_count % 64] = mem_wdata;
      wr_count++;
    end
  end

  always @(negedge clk)
    if (resetn && tx_valid && tx_ready) begin
      tx_last = tx_data;
      tx_count++;
    end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_valid = 1'b1; rx_data = b;
    @(negedge clk); rx_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_msg9(input logic [31:0] crcw);
    send_byte(8'h52);
    send_word(32'd9);
    for (int i = 0; i < 9; i++) send_byte(msg[i]);
    send_word(crcw);
  endtask

  task automatic wait_tx(input int base, input string nm);
    int n = 0;
    while (tx_count == base && n < 500) begin @(negedge clk); n++; end
    total++;
    if (tx_count == base) $display("FAIL %s_tx_wait no response byte, got count %0d need %0d", nm, tx_count, base + 1);
    else pass++;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++;
    if ({tx_valid, tx_data, mem_req, mem_addr, mem_wdata, cpu_resetn, busy, upload_ok} !== '0)
      $display("FAIL reset_outputs got tx_v=%b tx_d=%h req=%b addr=%h wd=%h cpu=%b busy=%b ok=%b need all 0",
               tx_valid, tx_data, mem_req, mem_addr, mem_wdata, cpu_resetn, busy, upload_ok);
    else pass++;
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_good_upload;
    int wb = wr_count, tb = tx_count;
    send_msg9(32'hCBF43926);
    wait_tx(tb, "good");
    repeat (2) @(negedge clk);
    total++; if (tx_last !== 8'h06) $display("FAIL good_tx got %h need 06", tx_last); else pass++;
    total++; if (upload_ok !== 1'b1) $display("FAIL good_upload_ok got %b need 1", upload_ok); else pass++;
    total++; if (wr_count - wb !== 5) $display("FAIL good_wr_count got %0d need 5", wr_count - wb); else pass++;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (wr_addr_log[(wb + i) % 64] !== 18'(i) || wr_data_log[(wb + i) % 64] !== exp_w[i])
        $display("FAIL good_word%0d got @%h=%h need @%h=%h", i, wr_addr_log[(wb + i) % 64],
                 wr_data_log[(wb + i) % 64], i, exp_w[i]);
      else pass++;
    end
    total++; if (cpu_resetn !== 1'b0 || busy !== 1'b0) $display("FAIL good_idle got cpu=%b busy=%b need 0 0", cpu_resetn, busy); else pass++;
  endtask

  task automatic test_cpu_release;
    int tb;
    send_byte(8'h72);
    send_byte(8'h0A);
    total++; if (cpu_resetn !== 1'b1 || busy !== 1'b0) $display("FAIL release_cpu got cpu=%b busy=%b need 1 0", cpu_resetn, busy); else pass++;
    tb = tx_count;
    @(negedge clk); rx_valid = 1'b1; rx_data = 8'h52;
    @(negedge clk); rx_valid = 1'b0;
    total++; if (cpu_resetn !== 1'b0 || busy !== 1'b1) $display("FAIL rehold_cpu got cpu=%b busy=%b need 0 1", cpu_resetn, busy); else pass++;
    wait_tx(tb, "rehold_timeout");
    total++; if (tx_last !== 8'h15 || busy !== 1'b0) $display("FAIL rehold_nak got tx=%h busy=%b need 15 0", tx_last, busy); else pass++;
  endtask

  task automatic test_bad_crc;
    int wb = wr_count, tb = tx_count;
    tx_ready = 1'b0;
    send_msg9(32'h0);
    total++; if (tx_valid !== 1'b1 || tx_data !== 8'h15 || busy !== 1'b1 || tx_count != tb)
      $display("FAIL badcrc_hold got v=%b d=%h busy=%b need 1 15 1", tx_valid, tx_data, busy); else pass++;
    @(posedge clk); #1 tx_ready = 1'b1;
    wait_tx(tb, "badcrc");
    repeat (2) @(negedge clk);
    total++; if (tx_last !== 8'h15) $display("FAIL badcrc_tx got %h need 15", tx_last); else pass++;
    total++; if (upload_ok !== 1'b0 || cpu_resetn !== 1'b0 || busy !== 1'b0)
      $display("FAIL badcrc_state got ok=%b cpu=%b busy=%b need 0 0 0", upload_ok, cpu_resetn, busy); else pass++;
    total++; if (wr_count - wb !== 5 || wr_data_log[(wb + 4) % 64] !== 16'h0039)
      $display("FAIL badcrc_writes got %0d last=%h need 5 0039", wr_count - wb, wr_data_log[(wb + 4) % 64]); else pass++;
  endtask

  task automatic test_size_too_big;
    int wb = wr_count, tb = tx_count;
    send_byte(8'h52);
    send_word(32'h0008_0001);
    total++; if (tx_count !== tb + 1 || tx_last !== 8'h15) $display("FAIL big_nak got count+%0d tx=%h need 1 15", tx_count - tb, tx_last); else pass++;
    total++; if (wr_count !== wb || busy !== 1'b0) $display("FAIL big_idle got writes=%0d busy=%b need 0 0", wr_count - wb, busy); else pass++;
  endtask

  task automatic test_timeout;
    int wb = wr_count, tb = tx_count;
    send_byte(8'h52);
    send_word(32'd4);
    send_byte(8'h61);
    send_byte(8'h62);
    wait_tx(tb, "timeout");
    total++; if (tx_last !== 8'h15 || busy !== 1'b0) $display("FAIL timeout_nak got tx=%h busy=%b need 15 0", tx_last, busy); else pass++;
    total++; if (wr_count - wb !== 1 || wr_data_log[wb % 64] !== 16'h6261)
      $display("FAIL timeout_word got %0d %h need 1 6261", wr_count - wb, wr_data_log[wb % 64]); else pass++;
    tb = tx_count;
    send_msg9(32'hCBF43926);
    wait_tx(tb, "after_timeout");
    repeat (2) @(negedge clk);
    total++; if (tx_last !== 8'h06 || upload_ok !== 1'b1) $display("FAIL after_timeout got tx=%h ok=%b need 06 1", tx_last, upload_ok); else pass++;
  endtask

  task automatic test_zero_size;
    int wb = wr_count, tb = tx_count;
    send_byte(8'h52);
    send_word(32'd0);
    send_word(32'd0);
    wait_tx(tb, "zero");
    repeat (2) @(negedge clk);
    total++; if (tx_last !== 8'h06 || upload_ok !== 1'b1 || wr_count !== wb)
      $display("FAIL zero_ack got tx=%h ok=%b writes=%0d need 06 1 0", tx_last, upload_ok, wr_count - wb); else pass++;
  endtask

  task automatic test_overrun;
    int wb = wr_count, tb = tx_count;
    @(posedge clk); #1 hold_ready = 1'b1;
    send_byte(8'h52);
    send_word(32'd9);
    send_byte(msg[0]);
    send_byte(msg[1]);
    total++; if (mem_req !== 1'b1 || mem_addr !== 18'd0 || mem_wdata !== 16'h3231)
      $display("FAIL overrun_hold got req=%b addr=%h wd=%h need 1 0 3231", mem_req, mem_addr, mem_wdata); else pass++;
    send_byte(8'h55);
    total++; if (mem_req !== 1'b1 || mem_wdata !== 16'h3231)
      $display("FAIL overrun_stable got req=%b wd=%h need 1 3231", mem_req, mem_wdata); else pass++;
    @(posedge clk); #1 hold_ready = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 2; i < 9; i++) send_byte(msg[i]);
    send_word(32'hCBF43926);
    wait_tx(tb, "overrun");
    repeat (2) @(negedge clk);
    total++; if (tx_last !== 8'h15 || upload_ok !== 1'b0) $display("FAIL overrun_nak got tx=%h ok=%b need 15 0", tx_last, upload_ok); else pass++;
    total++; if (wr_count - wb !== 5 || wr_data_log[wb % 64] !== 16'h3231 || wr_data_log[(wb + 1) % 64] !== 16'h3433)
      $display("FAIL overrun_writes got %0d %h %h need 5 3231 3433", wr_count - wb,
               wr_data_log[wb % 64], wr_data_log[(wb + 1) % 64]); else pass++;
  endtask

  task automatic test_reset_mid_data;
    send_byte(8'h52);
    send_word(32'd9);
    for (int i = 0; i < 3; i++) send_byte(msg[i]);
    total++; if (mem_addr !== 18'd1 || mem_wdata !== 16'h0033 || busy !== 1'b1)
      $display("FAIL middata_pre got addr=%h wd=%h busy=%b need 1 0033 1", mem_addr, mem_wdata, busy); else pass++;
    @(negedge clk); resetn = 1'b0;
    #1;
    total++;
    if ({tx_valid, tx_data, mem_req, mem_addr, mem_wdata, cpu_resetn, busy, upload_ok} !== '0)
      $display("FAIL middata_reset got tx_v=%b tx_d=%h req=%b addr=%h wd=%h cpu=%b busy=%b ok=%b need all 0",
               tx_valid, tx_data, mem_req, mem_addr, mem_wdata, cpu_resetn, busy, upload_ok);
    else pass++;
    @(negedge clk); resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_good_upload;
    test_cpu_release;
    test_bad_crc;
    test_size_too_big;
    test_timeout;
    test_zero_size;
    test_overrun;
    test_reset_mid_data;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
